// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory sequencer.
package lsu_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StDone = 2'd2,
      StErr  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      SzB = 2'd0,
      SzH = 2'd1,
      SzW = 2'd2,
      SzD = 2'd3
   } size_e;

   localparam logic [1:0] ErrNone     = 2'd0;
   localparam logic [1:0] ErrMisalign = 2'd1;
   localparam logic [1:0] ErrIllegal  = 2'd2;
   localparam logic [1:0] ErrTimeout  = 2'd3;

   localparam int unsigned DefToCycles = 256;

   function automatic logic is_onehot4(logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   // Size flags ordered {d, w, h, b}; only meaningful once is_onehot4 holds.
   function automatic size_e enc_size(logic [3:0] v);
      if (v[3]) return SzD;
      else if (v[2]) return SzW;
      else if (v[1]) return SzH;
      else return SzB;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: byte enables and store shift on the way out, load shift and
// sign/zero extension on the way back.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [1:0]      st_size,
   input  logic [2:0]      st_off,
   input  logic [XLEN-1:0] st_data,
   output logic [7:0]      be,
   output logic [XLEN-1:0] st_lane,
   input  logic [1:0]      ld_size,
   input  logic [2:0]      ld_off,
   input  logic            ld_zext,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] ld_fmt
);

   logic [XLEN-1:0] raw;

   always_comb begin
      case (st_size)
         SzB:     be = 8'h01 << st_off;
         SzH:     be = 8'h03 << st_off;
         SzW:     be = 8'h0F << st_off;
         default: be = 8'hFF;
      endcase
      st_lane = st_data << {st_off, 3'b000};
   end

   always_comb begin
      raw = rdata >> {ld_off, 3'b000};
      case (ld_size)
         SzB:     ld_fmt = {{(XLEN-8){~ld_zext & raw[7]}}, raw[7:0]};
         SzH:     ld_fmt = {{(XLEN-16){~ld_zext & raw[15]}}, raw[15:0]};
         SzW:     ld_fmt = {{(XLEN-32){~ld_zext & raw[31]}}, raw[31:0]};
         default: ld_fmt = raw;
      endcase
   end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer: checks the decoded op, runs one req/ack transaction on
// the data-memory port and returns a formatted load result or an error code.
module lsu_mem_sequencer
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned TO_CYCLES = DefToCycles
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            mem_rd,
   input  logic            mem_wr,
   input  logic            ld_b,
   input  logic            ld_h,
   input  logic            ld_w,
   input  logic            ld_d,
   input  logic            ld_us,
   input  logic            sw_b,
   input  logic            sw_h,
   input  logic            sw_w,
   input  logic            sw_d,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            dm_req,
   output logic            dm_we,
   output logic [XLEN-1:0] dm_addr,
   output logic [7:0]      dm_be,
   output logic [XLEN-1:0] dm_wdata,
   input  logic            dm_ack,
   input  logic [XLEN-1:0] dm_rdata,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] ld_data,
   output logic            err,
   output logic [1:0]      err_code
);

   localparam int unsigned CntW = $clog2(TO_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(TO_CYCLES - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            we_q, we_d, us_q, us_d;
   logic [1:0]      size_q, size_d, code_q, code_d;
   logic [2:0]      off_q, off_d;
   logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d_nxt;
   logic [7:0]      be_q, be_d;

   logic [3:0]      sel;
   logic [1:0]      req_size;
   logic            illegal, misalign;
   logic [7:0]      be_new;
   logic [XLEN-1:0] lane_new, ld_fmt;

   assign sel      = mem_rd ? {ld_d, ld_w, ld_h, ld_b} : {sw_d, sw_w, sw_h, sw_b};
   assign req_size = enc_size(sel);
   assign illegal  = (mem_rd == mem_wr) || !is_onehot4(sel);

   always_comb begin
      case (req_size)
         SzH:     misalign = addr[0];
         SzW:     misalign = |addr[1:0];
         SzD:     misalign = |addr[2:0];
         default: misalign = 1'b0;
      endcase
   end

   lsu_align #(.XLEN(XLEN)) u_align (
      .st_size (req_size),
      .st_off  (addr[2:0]),
      .st_data (wdata),
      .be      (be_new),
      .st_lane (lane_new),
      .ld_size (size_q),
      .ld_off  (off_q),
      .ld_zext (us_q),
      .rdata   (dm_rdata),
      .ld_fmt  (ld_fmt)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      us_d     = us_q;
      size_d   = size_q;
      off_d    = off_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      ld_d_nxt = ld_q;
      code_d   = code_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (illegal) begin
                  state_d = StErr;
                  code_d  = ErrIllegal;
               end else if (misalign) begin
                  state_d = StErr;
                  code_d  = ErrMisalign;
               end else begin
                  state_d = StReq;
                  cnt_d   = '0;
                  we_d    = mem_wr;
                  us_d    = ld_us;
                  size_d  = req_size;
                  off_d   = addr[2:0];
                  addr_d  = {addr[XLEN-1:3], 3'b000};
                  be_d    = be_new;
                  wdata_d = lane_new;
               end
            end
         end
         StReq: begin
            // An ack on the last counted cycle still completes normally.
            if (dm_ack) begin
               state_d  = StDone;
               ld_d_nxt = we_q ? '0 : ld_fmt;
            end else if (cnt_q == CntMax) begin
               state_d = StErr;
               code_d  = ErrTimeout;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         us_q    <= 1'b0;
         size_q  <= SzB;
         off_q   <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         ld_q    <= '0;
         code_q  <= ErrNone;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         us_q    <= us_d;
         size_q  <= size_d;
         off_q   <= off_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         ld_q    <= ld_d_nxt;
         code_q  <= code_d;
      end
   end

   assign dm_req   = (state_q == StReq);
   assign dm_we    = we_q;
   assign dm_addr  = addr_q;
   assign dm_be    = be_q;
   assign dm_wdata = wdata_q;
   assign stall    = ((state_q == StIdle) && start) || (state_q == StReq);
   assign done     = (state_q == StDone);
   assign err      = (state_q == StErr);
   assign ld_data  = ld_q;
   assign err_code = code_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer: vector table of single transactions plus
// hand sequences for timeout, ack on the last count, stray ack and reset.
module tb_lsu_mem_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, mem_rd, mem_wr, ld_b, ld_h, ld_w, ld_d, ld_us;
   logic        sw_b, sw_h, sw_w, sw_d;
   logic [63:0] addr, wdata, dm_addr, dm_wdata, dm_rdata, ld_data;
   logic        dm_req, dm_we, dm_ack, stall, done, err;
   logic [7:0]  dm_be;
   logic [1:0]  err_code;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_mem_sequencer #(.XLEN(64), .TO_CYCLES(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr),
      .ld_b     (ld_b),
      .ld_h     (ld_h),
      .ld_w     (ld_w),
      .ld_d     (ld_d),
      .ld_us    (ld_us),
      .sw_b     (sw_b),
      .sw_h     (sw_h),
      .sw_w     (sw_w),
      .sw_d     (sw_d),
      .addr     (addr),
      .wdata    (wdata),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_be    (dm_be),
      .dm_wdata (dm_wdata),
      .dm_ack   (dm_ack),
      .dm_rdata (dm_rdata),
      .stall    (stall),
      .done     (done),
      .ld_data  (ld_data),
      .err      (err),
      .err_code (err_code)
   );

   typedef struct {
      bit          rd;
      bit          wr;
      logic [3:0]  ld;    // {d, w, h, b}
      bit          us;
      logic [3:0]  sw;    // {d, w, h, b}
      logic [63:0] a;
      logic [63:0] wd;
      logic [63:0] rdat;
      int          dly;
      bit          eerr;
      logic [1:0]  ecode;
      logic [7:0]  ebe;
      logic [63:0] ewd;
      logic [63:0] eld;
   } vec_t;

   vec_t vecs [16];

   function automatic vec_t mk(bit rd, bit wr, logic [3:0] ld, bit us, logic [3:0] sw,
                               logic [63:0] a, logic [63:0] wd, logic [63:0] rdat, int dly,
                               bit eerr, logic [1:0] ecode, logic [7:0] ebe,
                               logic [63:0] ewd, logic [63:0] eld);
      vec_t v;
      v.rd = rd; v.wr = wr; v.ld = ld; v.us = us; v.sw = sw; v.a = a; v.wd = wd;
      v.rdat = rdat; v.dly = dly; v.eerr = eerr; v.ecode = ecode; v.ebe = ebe;
      v.ewd = ewd; v.eld = eld;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_op();
      start = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; ld_us = 1'b0;
      {ld_d, ld_w, ld_h, ld_b} = 4'b0;
      {sw_d, sw_w, sw_h, sw_b} = 4'b0;
      addr = '0; wdata = '0;
   endtask

   task automatic drive_op(input vec_t v);
      start = 1'b1; mem_rd = v.rd; mem_wr = v.wr; ld_us = v.us;
      {ld_d, ld_w, ld_h, ld_b} = v.ld;
      {sw_d, sw_w, sw_h, sw_b} = v.sw;
      addr = v.a; wdata = v.wd;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      @(negedge clk);
      chk({tag, "_idle_done"}, {63'd0, done}, 64'd0);
      chk({tag, "_idle_err"}, {63'd0, err}, 64'd0);
      drive_op(v);
      #1 chk({tag, "_stall_start"}, {63'd0, stall}, 64'd1);
      @(negedge clk);
      clear_op();
      if (v.eerr) begin
         chk({tag, "_err"}, {63'd0, err}, 64'd1);
         chk({tag, "_code"}, {62'd0, err_code}, {62'd0, v.ecode});
         chk({tag, "_noreq"}, {63'd0, dm_req}, 64'd0);
         chk({tag, "_err_stall"}, {63'd0, stall}, 64'd0);
      end else begin
         chk({tag, "_req"}, {63'd0, dm_req}, 64'd1);
         chk({tag, "_we"}, {63'd0, dm_we}, {63'd0, v.wr});
         chk({tag, "_addr"}, dm_addr, {v.a[63:3], 3'b000});
         chk({tag, "_be"}, {56'd0, dm_be}, {56'd0, v.ebe});
         chk({tag, "_wdata"}, dm_wdata, v.ewd);
         repeat (v.dly) @(negedge clk);
         chk({tag, "_req_held"}, {63'd0, dm_req}, 64'd1);
         chk({tag, "_done_early"}, {63'd0, done}, 64'd0);
         dm_ack = 1'b1;
         dm_rdata = v.rdat;
         @(negedge clk);
         dm_ack = 1'b0;
         dm_rdata = '0;
         chk({tag, "_done"}, {63'd0, done}, 64'd1);
         chk({tag, "_ld_data"}, ld_data, v.eld);
         chk({tag, "_done_stall"}, {63'd0, stall}, 64'd0);
         chk({tag, "_done_noreq"}, {63'd0, dm_req}, 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      vec_t v;
      rst_n = 1'b0;
      dm_ack = 1'b0;
      dm_rdata = '0;
      clear_op();

      //        rd wr ld      us sw      addr        wdata                   rdata
      vecs[0]  = mk(0, 1, 4'b0000, 0, 4'b0001, 64'h1003, 64'hAB, 64'h0, 1,
                    0, 2'd0, 8'h08, 64'h0000_0000_AB00_0000, 64'h0);
      vecs[1]  = mk(1, 0, 4'b0010, 0, 4'b0000, 64'h2006, 64'h0, 64'h8001_0000_0000_0000, 2,
                    0, 2'd0, 8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_8001);
      vecs[2]  = mk(1, 0, 4'b0010, 1, 4'b0000, 64'h2006, 64'h0, 64'h8001_0000_0000_0000, 0,
                    0, 2'd0, 8'hC0, 64'h0, 64'h0000_0000_0000_8001);
      vecs[3]  = mk(1, 0, 4'b0100, 0, 4'b0000, 64'h3002, 64'h0, 64'h0, 0,
                    1, 2'd1, 8'h00, 64'h0, 64'h0);
      vecs[4]  = mk(1, 1, 4'b0010, 0, 4'b0010, 64'h3001, 64'h0, 64'h0, 0,
                    1, 2'd2, 8'h00, 64'h0, 64'h0);
      vecs[5]  = mk(0, 1, 4'b0000, 0, 4'b0011, 64'h1000, 64'h0, 64'h0, 0,
                    1, 2'd2, 8'h00, 64'h0, 64'h0);
      vecs[6]  = mk(0, 1, 4'b0000, 0, 4'b0100, 64'h10C4, 64'hFFFF_FFFF_DEAD_BEEF, 64'h0, 3,
                    0, 2'd0, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0);
      vecs[7]  = mk(1, 0, 4'b0001, 0, 4'b0000, 64'h5005, 64'h0, 64'h0000_7F00_0000_0000, 1,
                    0, 2'd0, 8'h20, 64'h0, 64'h7F);
      vecs[8]  = mk(1, 0, 4'b0100, 0, 4'b0000, 64'h6004, 64'h0, 64'h8765_4321_0000_0000, 0,
                    0, 2'd0, 8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321);
      vecs[9]  = mk(1, 0, 4'b0001, 1, 4'b0000, 64'h7001, 64'h0, 64'h0000_0000_0000_9A00, 0,
                    0, 2'd0, 8'h02, 64'h0, 64'h9A);
      vecs[10] = mk(0, 1, 4'b0000, 0, 4'b1000, 64'h8004, 64'h0, 64'h0, 0,
                    1, 2'd1, 8'h00, 64'h0, 64'h0);
      vecs[11] = mk(1, 0, 4'b0010, 0, 4'b0000, 64'h8001, 64'h0, 64'h0, 0,
                    1, 2'd1, 8'h00, 64'h0, 64'h0);
      vecs[12] = mk(1, 0, 4'b0000, 0, 4'b0000, 64'h8000, 64'h0, 64'h0, 0,
                    1, 2'd2, 8'h00, 64'h0, 64'h0);
      vecs[13] = mk(0, 0, 4'b0001, 0, 4'b0001, 64'h8000, 64'h0, 64'h0, 0,
                    1, 2'd2, 8'h00, 64'h0, 64'h0);
      vecs[14] = mk(0, 1, 4'b0000, 0, 4'b0010, 64'h200A, 64'h1234_5678, 64'h0, 1,
                    0, 2'd0, 8'h0C, 64'h0000_1234_5678_0000, 64'h0);
      vecs[15] = mk(1, 0, 4'b1000, 1, 4'b0000, 64'h4000, 64'h0, 64'h1122_3344_5566_7788, 0,
                    0, 2'd0, 8'hFF, 64'h0, 64'h1122_3344_5566_7788);

      #3;
      chk("rst_req", {63'd0, dm_req}, 64'd0);
      chk("rst_stall", {63'd0, stall}, 64'd0);
      chk("rst_done_err", {62'd0, done, err}, 64'd0);
      chk("rst_addr", dm_addr, 64'd0);
      chk("rst_be_code", {54'd0, dm_be, err_code}, 64'd0);
      chk("rst_wdata", dm_wdata, 64'd0);
      chk("rst_ld_data", ld_data, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Ack raised on the final counted REQ cycle must complete, not time out.
      @(negedge clk);
      v = mk(1, 0, 4'b0001, 0, 4'b0000, 64'h9001, 64'h0, 64'h0, 0,
             0, 2'd0, 8'h02, 64'h0, 64'h0);
      drive_op(v);
      @(negedge clk);
      clear_op();
      repeat (7) @(negedge clk);
      chk("lastcnt_req", {63'd0, dm_req}, 64'd1);
      dm_ack = 1'b1;
      dm_rdata = 64'h0000_0000_0000_FF00;
      @(negedge clk);
      dm_ack = 1'b0;
      dm_rdata = '0;
      chk("lastcnt_done", {63'd0, done}, 64'd1);
      chk("lastcnt_noerr", {63'd0, err}, 64'd0);
      chk("lastcnt_ld", ld_data, 64'hFFFF_FFFF_FFFF_FFFF);

      // Timeout: dm_req holds for exactly TO_CYCLES cycles, then err code 3.
      @(negedge clk);
      drive_op(v);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         clear_op();
         if (dm_req) n++;
         else break;
      end
      chk("to_req_cycles", 64'(n), 64'd8);
      chk("to_err", {63'd0, err}, 64'd1);
      chk("to_code", {62'd0, err_code}, 64'd3);
      chk("to_stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      chk("to_idle", {62'd0, err, dm_req}, 64'd0);

      // Stray ack while idle does nothing.
      dm_ack = 1'b1;
      @(negedge clk);
      dm_ack = 1'b0;
      chk("stray_ack", {61'd0, done, dm_req, stall}, 64'd0);

      // Reset in the middle of a wait drops dm_req at once and yields no pulse.
      v = mk(1, 0, 4'b0100, 0, 4'b0000, 64'h4000, 64'h0, 64'h0, 0,
             0, 2'd0, 8'h0F, 64'h0, 64'h0);
      @(negedge clk);
      drive_op(v);
      @(negedge clk);
      clear_op();
      chk("mid_req", {63'd0, dm_req}, 64'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_req", {63'd0, dm_req}, 64'd0);
      chk("mid_rst_stall", {63'd0, stall}, 64'd0);
      chk("mid_rst_be", {56'd0, dm_be}, 64'd0);
      @(negedge clk);
      chk("mid_rst_pulse", {62'd0, done, err}, 64'd0);
      rst_n = 1'b1;
      run_vec(vecs[15], "post_rst_ld_d");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
